// File: rtl/param_register_file.sv
`default_nettype none
// ============================================================================
// Module   : param_register_file
// Brief    : Parametrised 1W/2R register file with registered reads and a
//            reset-driven init sequencer that loads a fixed pattern.
// Revision : 1.0 - initial release
// ============================================================================
module param_register_file #(
    parameter int WIDTH      = 4,
    parameter int DEPTH      = 8,
    parameter int INIT_COUNT = 4,
    parameter int BYPASS     = 1,
    localparam int ADDR_W    = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RF_we,
    input  logic [ADDR_W-1:0] RF_wad,
    input  logic [WIDTH-1:0]  RF_wd,
    input  logic [ADDR_W-1:0] RF_ad1,
    input  logic [ADDR_W-1:0] RF_ad2,
    output logic [WIDTH-1:0]  RF_d1,
    output logic [WIDTH-1:0]  RF_d2,
    output logic              RF_ready
);

    typedef enum logic [0:0] {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   cnt, cnt_nxt;
    logic                ready_nxt;
    logic [WIDTH-1:0]    d1_nxt, d2_nxt;

    // Storage carries no reset so it can map onto distributed RAM.
    logic [WIDTH-1:0]    mem [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [WIDTH-1:0]    mem_wd;
    logic [WIDTH-1:0]    init_val;

    assign init_val = (int'(cnt) < INIT_COUNT) ? WIDTH'(cnt) : '0;

    function automatic logic in_range(input logic [ADDR_W-1:0] ad);
        return int'(ad) < DEPTH;
    endfunction

    // Out-of-range reads return 0; collision handling depends on BYPASS.
    function automatic logic [WIDTH-1:0] read_port(
        input logic [ADDR_W-1:0] ad,
        input logic              we,
        input logic [ADDR_W-1:0] wad,
        input logic [WIDTH-1:0]  wd
    );
        if (!in_range(ad)) begin
            return '0;
        end
        if ((BYPASS != 0) && we && (wad == ad)) begin
            return wd;
        end
        return mem[ad];
    endfunction

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ready_nxt = RF_ready;
        d1_nxt    = '0;
        d2_nxt    = '0;
        mem_we    = 1'b0;
        mem_addr  = RF_wad;
        mem_wd    = RF_wd;
        case (state)
            S_INIT: begin
                mem_we   = 1'b1;
                mem_addr = cnt;
                mem_wd   = init_val;
                if (int'(cnt) == DEPTH - 1) begin
                    state_nxt = S_RUN;
                    ready_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_RUN: begin
                mem_we = RF_we && in_range(RF_wad);
                d1_nxt = read_port(RF_ad1, RF_we, RF_wad, RF_wd);
                d2_nxt = read_port(RF_ad2, RF_we, RF_wad, RF_wd);
            end
            default: begin
                state_nxt = S_INIT;
                ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_INIT;
            cnt      <= '0;
            RF_ready <= 1'b0;
            RF_d1    <= '0;
            RF_d2    <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            RF_ready <= ready_nxt;
            RF_d1    <= d1_nxt;
            RF_d2    <= d2_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && mem_we) begin
            mem[mem_addr] <= mem_wd;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_register_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_param_register_file
// Brief    : Directed bench for param_register_file (default, read-first and
//            non-power-of-2 instances driven from shared stimulus).
// Revision : 1.0 - initial release
// ============================================================================
module tb_param_register_file;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       we = 1'b0;
    logic [2:0] wad = '0;
    logic [3:0] wd = '0;
    logic [2:0] ad1 = '0;
    logic [2:0] ad2 = '0;

    logic [3:0] d1a, d2a, d1b, d2b, d1c, d2c;
    logic       rdya, rdyb, rdyc;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    // a: defaults (write-first), b: read-first, c: DEPTH=6 all initialised
    param_register_file #(.WIDTH(4), .DEPTH(8), .INIT_COUNT(4), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .RF_we(we), .RF_wad(wad), .RF_wd(wd),
        .RF_ad1(ad1), .RF_ad2(ad2), .RF_d1(d1a), .RF_d2(d2a), .RF_ready(rdya));

    param_register_file #(.WIDTH(4), .DEPTH(8), .INIT_COUNT(4), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .RF_we(we), .RF_wad(wad), .RF_wd(wd),
        .RF_ad1(ad1), .RF_ad2(ad2), .RF_d1(d1b), .RF_d2(d2b), .RF_ready(rdyb));

    param_register_file #(.WIDTH(4), .DEPTH(6), .INIT_COUNT(6), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .RF_we(we), .RF_wad(wad), .RF_wd(wd),
        .RF_ad1(ad1), .RF_ad2(ad2), .RF_d1(d1c), .RF_d2(d2c), .RF_ready(rdyc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held for two edges
        tick();
        tick();
        chk("rst_ready_a", rdya, 0);
        chk("rst_d1_a", d1a, 0);
        chk("rst_d2_a", d2a, 0);
        chk("rst_ready_c", rdyc, 0);
        reset = 1'b0;

        // Init sequence with a write attempted at init edge 2
        for (int i = 1; i <= 8; i++) begin
            if (i == 2) begin
                we = 1'b1; wad = 3'd6; wd = 4'hF;
            end else begin
                we = 1'b0;
            end
            tick();
            chk($sformatf("init_ready_a_%0d", i), rdya, (i == 8) ? 1 : 0);
            chk($sformatf("init_ready_b_%0d", i), rdyb, (i == 8) ? 1 : 0);
            chk($sformatf("init_ready_c_%0d", i), rdyc, (i >= 6) ? 1 : 0);
            if (i < 8) chk($sformatf("init_d1_a_%0d", i), d1a, 0);
        end
        we = 1'b0;

        // Init pattern readback
        for (int a = 0; a < 8; a++) begin
            ad1 = 3'(a);
            ad2 = 3'(7 - a);
            tick();
            chk($sformatf("pat_d1_a_%0d", a), d1a, (a < 4) ? 8'(a) : 0);
            chk($sformatf("pat_d2_a_%0d", a), d2a, ((7 - a) < 4) ? 8'(7 - a) : 0);
            chk($sformatf("pat_d1_b_%0d", a), d1b, (a < 4) ? 8'(a) : 0);
            chk($sformatf("pat_d1_c_%0d", a), d1c, (a < 6) ? 8'(a) : 0);
        end

        // Write to address 7: dropped on the 6-deep file, valid on the 8-deep ones
        we = 1'b1; wad = 3'd7; wd = 4'hC; ad1 = 3'd7; ad2 = 3'd7;
        tick();
        chk("oor_coll_d1_c", d1c, 0);
        chk("oor_coll_d1_a", d1a, 8'hC);
        chk("oor_coll_d1_b", d1b, 0);
        we = 1'b0;
        for (int a = 0; a < 6; a++) begin
            ad1 = 3'(a);
            tick();
            chk($sformatf("oor_keep_c_%0d", a), d1c, 8'(a));
        end
        ad1 = 3'd7;
        tick();
        chk("oor_read_c", d1c, 0);
        chk("wr7_read_a", d1a, 8'hC);
        chk("wr7_read_b", d1b, 8'hC);

        // Basic write/read
        we = 1'b1; wad = 3'd5; wd = 4'hA; ad1 = 3'd0; ad2 = 3'd0;
        tick();
        we = 1'b0; ad1 = 3'd5; ad2 = 3'd4;
        tick();
        chk("basic_d1_a", d1a, 8'hA);
        chk("basic_d2_a", d2a, 0);
        chk("basic_d1_b", d1b, 8'hA);

        // Same-address collision on both ports
        we = 1'b1; wad = 3'd3; wd = 4'h7; ad1 = 3'd3; ad2 = 3'd3;
        tick();
        chk("coll_d1_a", d1a, 8'h7);
        chk("coll_d2_a", d2a, 8'h7);
        chk("coll_d1_b", d1b, 8'h3);
        chk("coll_d2_b", d2b, 8'h3);
        we = 1'b0;
        tick();
        chk("coll_after_d1_b", d1b, 8'h7);
        chk("coll_after_d2_b", d2b, 8'h7);

        // Reset mid-RUN
        we = 1'b1; wad = 3'd1; wd = 4'h9; ad1 = 3'd0; ad2 = 3'd0;
        tick();
        we = 1'b0; ad1 = 3'd1; ad2 = 3'd1;
        tick();
        chk("mid_wr_d1_a", d1a, 8'h9);
        chk("mid_wr_d2_b", d2b, 8'h9);
        reset = 1'b1;
        tick();
        chk("mid_rst_ready_a", rdya, 0);
        chk("mid_rst_d1_a", d1a, 0);
        chk("mid_rst_d2_a", d2a, 0);
        chk("mid_rst_ready_c", rdyc, 0);
        reset = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk($sformatf("reinit_ready_a_%0d", i), rdya, (i == 8) ? 1 : 0);
        end
        chk("reinit_d1_held_a", d1a, 0);
        tick();
        chk("reinit_e1_a", d1a, 8'h1);
        chk("reinit_e1_b", d2b, 8'h1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
`default_nettype wire
